// File: rtl/regfile_dump_reader.sv
// Walks a register-file address range through one read port and streams each
// (address, value) pair out on a valid/ready interface. All outputs are registered.
module regfile_dump_reader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  // state | meaning
  // IDLE  | waiting for start; range is latched on start
  // READ  | rf_addr has settled for a cycle; capture rf_data at the next edge
  // HOLD  | word presented on out_*; waits for the handshake
  // DONE  | one-cycle done pulse after the last word was accepted
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] last_q, last_nxt;
  logic [ADDR_W-1:0] rf_addr_nxt, out_addr_nxt;
  logic [DATA_W-1:0] out_data_nxt;
  logic              out_valid_nxt, busy_nxt, done_nxt;
  logic              hs;

  assign hs = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // abort outranks start and any pending handshake outcome
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start && !abort) state_nxt = S_READ;
      S_READ: state_nxt = abort ? S_IDLE : S_HOLD;
      S_HOLD: begin
        if (abort)   state_nxt = S_IDLE;
        else if (hs) state_nxt = (out_addr == last_q) ? S_DONE : S_READ;
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    last_nxt      = last_q;
    rf_addr_nxt   = rf_addr;
    out_addr_nxt  = out_addr;
    out_data_nxt  = out_data;
    out_valid_nxt = (state_nxt == S_HOLD);
    busy_nxt      = (state_nxt != S_IDLE);
    done_nxt      = (state_nxt == S_DONE);
    if (state == S_IDLE && state_nxt == S_READ) begin
      last_nxt    = last_addr;
      rf_addr_nxt = first_addr;
    end
    if (state == S_READ && state_nxt == S_HOLD) begin
      out_addr_nxt = rf_addr;
      out_data_nxt = rf_data;
    end
    // address wraps naturally at 2^ADDR_W
    if (state == S_HOLD && state_nxt == S_READ)
      rf_addr_nxt = rf_addr + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q    <= '0;
      rf_addr   <= '0;
      out_addr  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      last_q    <= last_nxt;
      rf_addr   <= rf_addr_nxt;
      out_addr  <= out_addr_nxt;
      out_data  <= out_data_nxt;
      out_valid <= out_valid_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: table of ranges, random ranges and ready
// patterns against a queue-based model, plus abort and async-reset sequences.
module tb_regfile_dump_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        out_ready = 1'b0;
  logic [4:0]  first_addr = '0;
  logic [4:0]  last_addr = '0;
  logic [4:0]  rf_addr, out_addr;
  logic [31:0] rf_data, out_data;
  logic        out_valid, busy, done;
  logic [31:0] regs [32];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // register 0 is hardwired to zero
  assign rf_data = (rf_addr == 5'd0) ? 32'd0 : regs[rf_addr];

  regfile_dump_reader #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .first_addr(first_addr), .last_addr(last_addr),
    .rf_addr(rf_addr), .rf_data(rf_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data),
    .busy(busy), .done(done)
  );

  typedef struct {
    logic [4:0] f;
    logic [4:0] l;
    int         mode;       // 0 ready always, 1 random ready, 2 stall word 2
    logic       inj;        // pulse a second start mid-dump
    int         exp_words;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // call at a negedge with the DUT idle; returns at the negedge after busy falls
  task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int mode,
                          input logic inj, input int exp_words);
    int n, got, cyc, last_hs, prev_hs, stall;
    logic prev_wait, seen_done;
    logic [4:0]  pa, pr;
    logic [31:0] pd;
    logic [4:0]  exp_addr [$];
    logic [31:0] exp_data [$];
    n = ((int'(l) - int'(f)) & 31) + 1;
    for (int i = 0; i < n; i++) begin
      logic [4:0] a;
      a = 5'((int'(f) + i) % 32);
      exp_addr.push_back(a);
      exp_data.push_back(a == 5'd0 ? 32'd0 : regs[a]);
    end
    got = 0; cyc = 0; last_hs = -10; prev_hs = -10; stall = 0;
    prev_wait = 1'b0; seen_done = 1'b0; pa = '0; pr = '0; pd = '0;
    first_addr = f; last_addr = l; start = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    first_addr = 5'($urandom); last_addr = 5'($urandom);
    check("busy_after_start", busy, 1);
    check("valid_after_start", out_valid, 0);
    cyc = 1;
    while (!seen_done && cyc < 400) begin
      start = (inj && cyc == 3 && !done);
      if (start) begin first_addr = f + 5'd3; last_addr = f + 5'd4; end
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: begin
          if (got == 1 && stall < 5) begin
            out_ready = 1'b0;
            if (out_valid) stall++;
          end else out_ready = 1'b1;
        end
      endcase
      if (done) begin
        seen_done = 1'b1;
        check("done_after_last_hs", cyc - last_hs, 1);
        check("busy_in_done", busy, 1);
        check("valid_in_done", out_valid, 0);
      end else if (out_valid) begin
        if (prev_wait) begin
          check("hold_addr", out_addr, pa);
          check("hold_data", out_data, pd);
          check("hold_rf_addr", rf_addr, pr);
        end
        if (out_ready) begin
          if (got < n) begin
            check("word_addr", out_addr, exp_addr[got]);
            check("word_data", out_data, exp_data[got]);
          end else check("word_overrun", got + 1, n);
          if (mode == 0) begin
            if (got == 0) check("first_word_latency", cyc, 2);
            else          check("word_interval", cyc - prev_hs, 2);
          end
          prev_hs = cyc; last_hs = cyc; got++;
        end
        prev_wait = !out_ready;
        pa = out_addr; pd = out_data; pr = rf_addr;
      end else prev_wait = 1'b0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; out_ready = 1'b0;
    check("done_seen", seen_done, 1);
    check("word_count", got, n);
    if (exp_words > 0) check("word_count_table", got, exp_words);
    if (mode == 2) check("stall_cycles", stall, 5);
    check("done_one_cycle", done, 0);
    check("busy_after_done", busy, 0);
  endtask

  vec_t vecs [6];

  initial begin
    bit found;
    vecs[0] = '{f:5'd1,  l:5'd3,  mode:0, inj:1'b0, exp_words:3};
    vecs[1] = '{f:5'd30, l:5'd1,  mode:0, inj:1'b0, exp_words:4};
    vecs[2] = '{f:5'd4,  l:5'd8,  mode:2, inj:1'b0, exp_words:5};
    vecs[3] = '{f:5'd10, l:5'd20, mode:0, inj:1'b1, exp_words:11};
    vecs[4] = '{f:5'd0,  l:5'd31, mode:1, inj:1'b0, exp_words:32};
    vecs[5] = '{f:5'd31, l:5'd0,  mode:0, inj:1'b0, exp_words:2};

    for (int i = 0; i < 32; i++) regs[i] = 32'h1000 + 32'(i) * 32'h11;
    regs[1] = 32'd11; regs[2] = 32'd22; regs[3] = 32'd33;
    regs[30] = 32'hAAAA_0030; regs[31] = 32'hBBBB_0031;

    #2 rst = 1'b0;
    #1;
    check("rst_rf_addr", rf_addr, 0);
    check("rst_out_addr", out_addr, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);

    foreach (vecs[k])
      run_dump(vecs[k].f, vecs[k].l, vecs[k].mode, vecs[k].inj, vecs[k].exp_words);

    // abort while word 2 of 0..31 is held
    first_addr = 5'd0; last_addr = 5'd31; start = 1'b1;
    @(negedge clk);
    start = 1'b0; out_ready = 1'b1; found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (out_valid && out_addr == 5'd1) begin
        found = 1'b1;
        out_ready = 1'b0; abort = 1'b1;
      end
      @(negedge clk);
    end
    abort = 1'b0; out_ready = 1'b0;
    check("abort_reached_word2", found, 1);
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    @(negedge clk);
    check("abort_no_done_later", done, 0);
    run_dump(5'd0, 5'd31, 0, 1'b0, 32);

    // asynchronous reset in the middle of HOLD
    regs[7] = 32'hA5A5_0007; regs[5] = 32'h0505_0505;
    first_addr = 5'd7; last_addr = 5'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0; out_ready = 1'b0; found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      if (out_valid) found = 1'b1;
      else @(negedge clk);
    end
    check("rst_reached_hold", found, 1);
    #2 rst = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_rf_addr", rf_addr, 0);
    check("midrst_out_addr", out_addr, 0);
    check("midrst_out_data", out_data, 0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    run_dump(5'd5, 5'd5, 0, 1'b0, 1);

    // random ranges, random register contents and ready patterns
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      run_dump(5'($urandom), 5'($urandom), int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
